riscv_csr_file: RTL
===================

RISCV_CSR_FILE -- requirements
Module: riscv_csr_file

Interface
REQ-001 Parameter HART_ID, default 32'h0, value returned by mhartid.
REQ-002 Parameter MISA_VALUE, default 32'h4000_0100 (RV32I), value returned by misa.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 csr_addr  input  12  CSR address for the current access.
REQ-006 csr_access  input  1  CSR instruction present this cycle.
REQ-007 csr_write_mode  input  2  00 NONE, 01 SET, 10 CLEAR, 11 REPLACE.
REQ-008 csr_wdata  input  32  final new value, already computed by the CSR ALU.
REQ-009 csr_rdata  output  32  current value of csr_addr, the ALU x operand.
REQ-010 csr_illegal  output  1  current access is illegal.
REQ-011 instr_retire  input  1  one instruction retired this cycle.
REQ-012 trap_valid  input  1  take a trap this cycle.
REQ-013 trap_pc / trap_cause / trap_tval  input  32 each  values for mepc / mcause / mtval.
REQ-014 mret  input  1  execute MRET this cycle.
REQ-015 ext_irq / timer_irq / sw_irq  input  1 each  level interrupt lines feeding mip bits 11/7/3.
REQ-016 trap_vector  output  32  {mtvec[31:2],2'b00}.
REQ-017 epc  output  32  current mepc.
REQ-018 irq_pending  output  1  mstatus.MIE & |(mip & mie).

Function
REQ-019 csr_rdata and csr_illegal are combinational on csr_addr and current state, zero-cycle latency.
REQ-020 Implemented CSRs: mstatus 0x300, misa 0x301, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344, mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82, cycle/cycleh 0xC00/0xC80, instret/instreth 0xC02/0xC82, mhartid 0xF14.
REQ-021 Unimplemented address: csr_rdata=0, csr_illegal=1 when csr_access=1.
REQ-022 Write occurs at the clock edge only when csr_access=1, csr_write_mode!=NONE, csr_illegal=0.
REQ-023 Write to a read-only address (csr_addr[11:10]==2'b11, plus misa and mip) with mode!=NONE: csr_illegal=1, no state change; NONE mode read is legal.
REQ-024 mstatus: only MIE bit3 and MPIE bit7 writable; MPP[12:11] reads 2'b11; other bits read 0.
REQ-025 mie: only bits 3, 7, 11 writable, others read 0.
REQ-026 mtvec, mepc: bits[1:0] forced to 0 on write; mscratch, mcause, mtval fully writable.
REQ-027 mip reads {20'b0, ext_irq, 3'b0, timer_irq, 3'b0, sw_irq, 3'b0} live.
REQ-028 mcycle (64-bit) increments by 1 every cycle; minstret (64-bit) increments when instr_retire=1; both wrap 2^64-1 -> 0.
REQ-029 Write to a counter half replaces that half with csr_wdata and suppresses the increment that cycle; other half unchanged (no carry from written low half).
REQ-030 Low half 0xFFFF_FFFF incrementing carries into the high half in the same cycle.
REQ-031 cycle/instret aliases read the m-counter values, read-only.
REQ-032 trap_valid=1: mepc<=trap_pc&~3, mcause<=trap_cause, mtval<=trap_tval, MPIE<=MIE, MIE<=0.
REQ-033 mret=1 (no trap): MIE<=MPIE, MPIE<=1.
REQ-034 Priority same cycle: trap_valid > mret > CSR write; a lower-priority update to mstatus/mepc/mcause/mtval is discarded; writes to other CSRs still commit.
REQ-035 Counters advance regardless of trap/mret.

Reset
REQ-036 rst=1 at an edge: mstatus MIE=MPIE=0, mie=0, mtvec=0, mscratch=0, mepc=0, mcause=0, mtval=0, mcycle=0, minstret=0; overrides all same-cycle writes, traps, increments.
REQ-037 During reset outputs follow reset state: trap_vector=0, epc=0, irq_pending=0; first increment on the first edge with rst=0.

Verification
REQ-038 Release reset, idle 10 cycles, read 0xB00 -> 10 (±pipeline offset fixed by bench), 0xB80 -> 0.
REQ-039 REPLACE 0x305 with 0x8000_0103 -> mtvec reads 0x8000_0100, trap_vector=0x8000_0100.
REQ-040 Set MIE via 0x300 SET 0x8, timer_irq=1, mie=0x80 -> irq_pending=1; trap_valid with pc 0x104, cause 0x8000_0007 -> MIE=0, MPIE=1, mepc=0x104, irq_pending=0; mret -> MIE=1.
REQ-041 REPLACE 0xB00 with 0xFFFF_FFFF, 0xB80 0 -> next cycle 0xB00=0, 0xB80=1.
REQ-042 Access 0xC00 with SET, and 0x7FF any mode -> csr_illegal=1, no state change; 0xC00 NONE -> csr_illegal=0.
REQ-043 trap_valid, mret, REPLACE mepc=0x200 same cycle -> mepc=trap_pc, MIE=0; rst asserted same cycle -> all reset values.

Source files
------------

// File: rtl/riscv_csr_file.sv
// RV32 machine-mode CSR file: trap/mret status, counters, interrupt pending.
// Reads are combinational; every update happens on the rising clock edge.
module riscv_csr_file #(
  parameter logic [31:0] HART_ID    = 32'h0,
  parameter logic [31:0] MISA_VALUE = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] csr_addr,
  input  logic        csr_access,
  input  logic [1:0]  csr_write_mode,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic        instr_retire,
  input  logic        trap_valid,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_tval,
  input  logic        mret,
  input  logic        ext_irq,
  input  logic        timer_irq,
  input  logic        sw_irq,
  output logic [31:0] trap_vector,
  output logic [31:0] epc,
  output logic        irq_pending
);
  localparam logic [31:0] MIE_MASK = 32'h0000_0888;

  logic        st_mie_q, st_mie_d;
  logic        st_mpie_q, st_mpie_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;
  logic [31:0] mstatus, mip;
  logic        impl, ro, wr, wr_sys;

  assign mstatus = {19'b0, 2'b11, 3'b0, st_mpie_q, 3'b0, st_mie_q, 3'b0};
  assign mip     = {20'b0, ext_irq, 3'b0, timer_irq, 3'b0, sw_irq, 3'b0};

  always_comb begin
    csr_rdata = '0;
    impl      = 1'b1;
    case (csr_addr)
      12'h300:          csr_rdata = mstatus;
      12'h301:          csr_rdata = MISA_VALUE;
      12'h304:          csr_rdata = mie_q;
      12'h305:          csr_rdata = mtvec_q;
      12'h340:          csr_rdata = mscratch_q;
      12'h341:          csr_rdata = mepc_q;
      12'h342:          csr_rdata = mcause_q;
      12'h343:          csr_rdata = mtval_q;
      12'h344:          csr_rdata = mip;
      12'hB00, 12'hC00: csr_rdata = mcycle_q[31:0];
      12'hB80, 12'hC80: csr_rdata = mcycle_q[63:32];
      12'hB02, 12'hC02: csr_rdata = minstret_q[31:0];
      12'hB82, 12'hC82: csr_rdata = minstret_q[63:32];
      12'hF14:          csr_rdata = HART_ID;
      default:          impl = 1'b0;
    endcase
  end

  assign ro = (csr_addr[11:10] == 2'b11) || (csr_addr == 12'h301) ||
              (csr_addr == 12'h344);
  assign csr_illegal = csr_access &
                       (~impl | (ro & (csr_write_mode != 2'b00)));
  assign wr     = csr_access & (csr_write_mode != 2'b00) & ~csr_illegal;
  // trap/mret own mstatus, mepc, mcause and mtval for this cycle
  assign wr_sys = wr & ~trap_valid & ~mret;

  always_comb begin
    st_mie_d   = st_mie_q;
    st_mpie_d  = st_mpie_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'b0, instr_retire};
    if (wr) begin
      case (csr_addr)
        12'h304: mie_d      = csr_wdata & MIE_MASK;
        12'h305: mtvec_d    = {csr_wdata[31:2], 2'b00};
        12'h340: mscratch_d = csr_wdata;
        12'hB00: mcycle_d   = {mcycle_q[63:32], csr_wdata};
        12'hB80: mcycle_d   = {csr_wdata, mcycle_q[31:0]};
        12'hB02: minstret_d = {minstret_q[63:32], csr_wdata};
        12'hB82: minstret_d = {csr_wdata, minstret_q[31:0]};
        default: ;
      endcase
    end
    if (wr_sys) begin
      case (csr_addr)
        12'h300: begin
          st_mie_d  = csr_wdata[3];
          st_mpie_d = csr_wdata[7];
        end
        12'h341: mepc_d   = {csr_wdata[31:2], 2'b00};
        12'h342: mcause_d = csr_wdata;
        12'h343: mtval_d  = csr_wdata;
        default: ;
      endcase
    end
    if (trap_valid) begin
      mepc_d    = {trap_pc[31:2], 2'b00};
      mcause_d  = trap_cause;
      mtval_d   = trap_tval;
      st_mpie_d = st_mie_q;
      st_mie_d  = 1'b0;
    end else if (mret) begin
      st_mie_d  = st_mpie_q;
      st_mpie_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_mie_q   <= 1'b0;
      st_mpie_q  <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      st_mie_q   <= st_mie_d;
      st_mpie_q  <= st_mpie_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  assign trap_vector = rst ? '0 : {mtvec_q[31:2], 2'b00};
  assign epc         = rst ? '0 : mepc_q;
  assign irq_pending = ~rst & st_mie_q & (|(mip & mie_q));

endmodule
